wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master arbiter for the 16-bit Wishbone B.4 pipelined bus. It shares one slave port between the instruction fetch unit (master 0) and the load/store unit (master 1). A grant is held for an entire bus cycle, which runs from `cyc` rise to `cyc` fall. A no-ack watchdog aborts hung cycles with an error pulse. The block sits between the CPU core's two bus masters and the external Wishbone interconnect.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: watchdog counter width. A timeout fires after 2^TIMEOUT_W−1 consecutive ackless granted cycles.

Ports (x = 0, 1):
- `clk_i` in 1: clock; all logic is on the rising edge.
- `reset_ni` in 1: reset, asynchronous, active-low.
- `mXadr_i` in 64: master address.
- `mXdat_i` in 16: master write data.
- `mXwe_i` in 1: master write enable.
- `mXsel_i` in 2: master byte lane select.
- `mXstb_i` in 1: master strobe.
- `mXcyc_i` in 1: master cycle.
- `mXstall_o` out 1: stall to master.
- `mXack_o` out 1: acknowledge to master.
- `mXerr_o` out 1: one-cycle timeout error to master.
- `mXdat_o` out 16: read data, `sdat_i` broadcast to both masters.
- `sadr_o` out 64, `sdat_o` out 16, `swe_o` out 1, `ssel_o` out 2, `sstb_o` out 1, `scyc_o` out 1: slave-side request.
- `sstall_i` in 1, `sack_i` in 1, `sdat_i` in 16: slave-side response.

## Operation
The state register takes one of five values: IDLE, G0, G1, D0, D1. Reset forces IDLE.

- **IDLE**
  - Both `mXstall_o` are 1. `scyc_o` and `sstb_o` are 0. `sadr_o`, `sdat_o`, `swe_o` and `ssel_o` are 0.
  - If any `mXcyc_i` is 1, the next state is GX of the winner (see Configuration for tie-break).
- **GX** (master X granted)
  - Slave outputs equal master X's inputs combinationally: `scyc_o = mXcyc_i`, `sstb_o = mXstb_i`.
  - `mXstall_o = sstall_i` and `mXack_o = sack_i`.
  - The other master sees stall = 1 and ack = 0.
- **Leaving GX**
  - If `mXcyc_i` is 0 and the other master's `cyc` is 1, go directly to G(other). There is no dead cycle.
  - If `mXcyc_i` is 0 and the other master's `cyc` is 0, go to IDLE.
- **Watchdog**
  - A counter of `TIMEOUT_W` bits clears on entering any GX, on `sack_i` = 1, and on `mXstb_i` = 1 with `sstall_i` = 0.
  - Otherwise it increments in GX while `mXcyc_i` = 1. It saturates and does not wrap.
  - When it reaches all-ones, `mXerr_o` pulses for exactly 1 cycle and the state moves to DX.
- **DX** (drain after timeout)
  - `scyc_o` and `sstb_o` are 0. `mXstall_o` = 1 and all acks are 0. A late `sack_i` is discarded.
  - Stay in DX until `mXcyc_i` = 0, then apply the same exit rules as GX.
- `mXdat_o` equals `sdat_i` in all states. A master qualifies read data with its own ack.
- **Reset mid-cycle**: the state goes to IDLE immediately. All outputs take their reset values asynchronously and the watchdog count clears.

## Timing
Reset values:
- `m0stall_o` = `m1stall_o` = 1.
- All acks, all errs, `scyc_o` and `sstb_o` are 0.
- `sadr_o`, `sdat_o`, `swe_o` and `ssel_o` are 0.

Latency and handshake rules:
- **Grant latency:** `cyc` rising in IDLE at edge N grants at edge N+1. The first unstalled strobe can reach the slave in cycle N+1.
- **Hand-off:** `cyc` falls at edge N for master X while the other master's `cyc` is 1. The other master is granted from edge N+1.
- **Pass-through:** the request, stall and ack paths are zero-latency combinational while granted. There is no added pipeline stage.
- **Err timing:** `mXerr_o` asserts in the cycle after the counter reaches all-ones. It is registered.
- **Simultaneous events:**
  - If `sack_i` and the watchdog limit coincide, the ack wins. The counter clears and no error is raised.
  - If the granted master's `cyc` falls while the other rises, hand-off takes precedence over IDLE.

## Configuration
Macro: `WBARB_RR_EN`.
- **Defined:** round-robin tie-break. On a simultaneous request from IDLE, the master not granted most recently wins. The last-grant flag resets to 1, so master 0 wins the first tie.
- **Undefined:** fixed priority. Master 1 (LSU) always wins a tie. The last-grant flag is not built.

## Test plan
- **Single master:** m0 `cyc`/`stb` at 0x1000 from IDLE with slave stall 0 and ack after 1 cycle → grant at the next edge, `sadr_o` = 0x1000, `m0ack_o` pulses, `m1stall_o` held at 1 throughout.
- **Tie:** m0 and m1 raise `cyc` on the same edge → G1 without the macro; G0 then G1 on a second tie with `WBARB_RR_EN`.
- **Hand-off:** m1 holds `cyc` while m0 finishes a 4-beat read → G1 on the edge after m0 drops `cyc`, with no IDLE cycle.
- **Timeout:** `TIMEOUT_W` = 4, m0 strobe accepted, slave never acks → `m0err_o` is a one-cycle pulse 15 cycles after the last clear; `scyc_o` falls; D0 held until m0 drops `cyc`; a late `sack_i` does not reach `m0ack_o`.
- **Ack at limit:** `sack_i` arrives on the cycle the counter reaches all-ones → no error, state remains G0.
- **Async reset:** `reset_ni` pulsed low for 3 ns between clock edges mid-transfer → outputs take reset values immediately, state is IDLE, and a new request is granted normally after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Two-master arbiter for a 16-bit Wishbone B.4 pipelined bus. Master 0
// (instruction fetch) and master 1 (load/store) share one slave port. A grant
// is held from cyc rise to cyc fall. While a master is granted, its request
// and the slave's stall/ack paths pass through combinationally. A no-ack
// watchdog aborts hung cycles: it raises a one-cycle error to the owner and
// drains until that master drops cyc.
//
// Build option:
//   WBARB_RR_EN  defined   -> round-robin tie-break from IDLE. The master not
//                             granted most recently wins; master 0 wins the
//                             first tie after reset.
//                undefined -> fixed priority. Master 1 wins every tie.
//
// Parameters:
//   TIMEOUT_W    watchdog width. The error fires once 2^TIMEOUT_W-1
//                consecutive granted cycles pass without progress.
//
// Ports (x = 0, 1):
//   clk_i, reset_ni                  clock, asynchronous active-low reset
//   mXadr_i/dat_i/we_i/sel_i         master request payload
//   mXstb_i, mXcyc_i                 master strobe / cycle
//   mXstall_o, mXack_o, mXerr_o      per-master stall, ack, timeout error
//   mXdat_o                          read data (sdat_i broadcast)
//   sadr_o/sdat_o/swe_o/ssel_o       slave request payload
//   sstb_o, scyc_o                   slave strobe / cycle
//   sstall_i, sack_i, sdat_i         slave response
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_arbiter #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  // master 0 (instruction fetch)
  input  logic [63:0] m0adr_i,
  input  logic [15:0] m0dat_i,
  input  logic        m0we_i,
  input  logic [1:0]  m0sel_i,
  input  logic        m0stb_i,
  input  logic        m0cyc_i,
  output logic        m0stall_o,
  output logic        m0ack_o,
  output logic        m0err_o,
  output logic [15:0] m0dat_o,
  // master 1 (load/store)
  input  logic [63:0] m1adr_i,
  input  logic [15:0] m1dat_i,
  input  logic        m1we_i,
  input  logic [1:0]  m1sel_i,
  input  logic        m1stb_i,
  input  logic        m1cyc_i,
  output logic        m1stall_o,
  output logic        m1ack_o,
  output logic        m1err_o,
  output logic [15:0] m1dat_o,
  // slave port
  output logic [63:0] sadr_o,
  output logic [15:0] sdat_o,
  output logic        swe_o,
  output logic [1:0]  ssel_o,
  output logic        sstb_o,
  output logic        scyc_o,
  input  logic        sstall_i,
  input  logic        sack_i,
  input  logic [15:0] sdat_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_G0   = 3'd1;
  localparam logic [2:0] S_G1   = 3'd2;
  localparam logic [2:0] S_D0   = 3'd3;
  localparam logic [2:0] S_D1   = 3'd4;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [1:0]           err_q, err_d;

  logic in_g0, in_g1, granted;
  logic act_cyc, act_stb;
  logic wd_clear, wd_hit, enter_g;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic pick_m1;

  assign in_g0   = (state_q == S_G0);
  assign in_g1   = (state_q == S_G1);
  assign granted = in_g0 | in_g1;

  // Signals of whichever master currently owns the bus (meaningful only
  // while granted).
  assign act_cyc = in_g1 ? m1cyc_i : m0cyc_i;
  assign act_stb = in_g1 ? m1stb_i : m0stb_i;

  // Progress on the bus: an ack, or a strobe the slave accepted.
  assign wd_clear = sack_i | (act_stb & ~sstall_i);
  assign wd_inc   = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_ONE;

  // Timeout when this cycle's increment lands on all-ones. An ack or an
  // accepted strobe in the same cycle wins, so no error is raised.
  assign wd_hit = granted & act_cyc & ~wd_clear & (wd_inc == WD_MAX);

`ifdef WBARB_RR_EN
  // 1: master 1 was granted most recently.
  logic last_q;

  assign pick_m1 = m1cyc_i & (~m0cyc_i | ~last_q);
`else
  assign pick_m1 = m1cyc_i;
`endif

  // Next-state logic. Leaving a grant or drain goes straight to the other
  // master when it is waiting; this gives a hand-off with no dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (m0cyc_i | m1cyc_i) state_d = pick_m1 ? S_G1 : S_G0;
      S_G0: begin
        if (!m0cyc_i)    state_d = m1cyc_i ? S_G1 : S_IDLE;
        else if (wd_hit) state_d = S_D0;
      end
      S_G1: begin
        if (!m1cyc_i)    state_d = m0cyc_i ? S_G0 : S_IDLE;
        else if (wd_hit) state_d = S_D1;
      end
      S_D0: if (!m0cyc_i) state_d = m1cyc_i ? S_G1 : S_IDLE;
      S_D1: if (!m1cyc_i) state_d = m0cyc_i ? S_G0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_g = ((state_d == S_G0) && (state_q != S_G0)) ||
                   ((state_d == S_G1) && (state_q != S_G1));

  // The watchdog only counts while a grant is live and stalled; every other
  // case (new grant, progress, idle, drain) leaves it at zero.
  always_comb begin
    wd_d = '0;
    if (granted && !enter_g && act_cyc && !wd_clear) wd_d = wd_inc;
  end

  assign err_d = {in_g1 & wd_hit, in_g0 & wd_hit};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

`ifdef WBARB_RR_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= 1'b1;
    end else if (enter_g) begin
      last_q <= (state_d == S_G1);
    end
  end
`endif

  // Slave request mux. Payload is forced to zero when nobody is granted, so
  // idle and drain states present a quiet bus.
  always_comb begin
    sadr_o = '0;
    sdat_o = '0;
    swe_o  = 1'b0;
    ssel_o = '0;
    sstb_o = 1'b0;
    scyc_o = 1'b0;
    if (in_g0) begin
      sadr_o = m0adr_i;
      sdat_o = m0dat_i;
      swe_o  = m0we_i;
      ssel_o = m0sel_i;
      sstb_o = m0stb_i;
      scyc_o = m0cyc_i;
    end else if (in_g1) begin
      sadr_o = m1adr_i;
      sdat_o = m1dat_i;
      swe_o  = m1we_i;
      ssel_o = m1sel_i;
      sstb_o = m1stb_i;
      scyc_o = m1cyc_i;
    end
  end

  // Response paths: only the owner sees the slave's stall/ack. A late ack
  // while draining is dropped because no grant state is active.
  assign m0stall_o = in_g0 ? sstall_i : 1'b1;
  assign m1stall_o = in_g1 ? sstall_i : 1'b1;
  assign m0ack_o   = in_g0 & sack_i;
  assign m1ack_o   = in_g1 & sack_i;
  assign m0err_o   = err_q[0];
  assign m1err_o   = err_q[1];
  assign m0dat_o   = sdat_i;
  assign m1dat_o   = sdat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps

module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [63:0] m0adr_i, m1adr_i;
  logic [15:0] m0dat_i, m1dat_i;
  logic        m0we_i, m1we_i;
  logic [1:0]  m0sel_i, m1sel_i;
  logic        m0stb_i, m1stb_i, m0cyc_i, m1cyc_i;
  logic        m0stall_o, m1stall_o, m0ack_o, m1ack_o, m0err_o, m1err_o;
  logic [15:0] m0dat_o, m1dat_o;
  logic [63:0] sadr_o;
  logic [15:0] sdat_o;
  logic        swe_o;
  logic [1:0]  ssel_o;
  logic        sstb_o, scyc_o;
  logic        sstall_i, sack_i;
  logic [15:0] sdat_i;

  int checks   = 0;
  int failures = 0;

`ifdef WBARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT_W(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0adr_i(m0adr_i), .m0dat_i(m0dat_i), .m0we_i(m0we_i), .m0sel_i(m0sel_i),
    .m0stb_i(m0stb_i), .m0cyc_i(m0cyc_i), .m0stall_o(m0stall_o),
    .m0ack_o(m0ack_o), .m0err_o(m0err_o), .m0dat_o(m0dat_o),
    .m1adr_i(m1adr_i), .m1dat_i(m1dat_i), .m1we_i(m1we_i), .m1sel_i(m1sel_i),
    .m1stb_i(m1stb_i), .m1cyc_i(m1cyc_i), .m1stall_o(m1stall_o),
    .m1ack_o(m1ack_o), .m1err_o(m1err_o), .m1dat_o(m1dat_o),
    .sadr_o(sadr_o), .sdat_o(sdat_o), .swe_o(swe_o), .ssel_o(ssel_o),
    .sstb_o(sstb_o), .scyc_o(scyc_o),
    .sstall_i(sstall_i), .sack_i(sack_i), .sdat_i(sdat_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 2 units after the rising edge and checked 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    reset_ni = 1'b0;
    m0adr_i = '0; m1adr_i = '0; m0dat_i = '0; m1dat_i = '0;
    m0we_i = 0; m1we_i = 0; m0sel_i = '0; m1sel_i = '0;
    m0stb_i = 0; m1stb_i = 0; m0cyc_i = 0; m1cyc_i = 0;
    sstall_i = 0; sack_i = 0; sdat_i = '0;

    // ---------------- reset values ----------------
    #2;
    $display("txn reset");
    chk("rst_m0stall", 64'(m0stall_o), 64'(1));
    chk("rst_m1stall", 64'(m1stall_o), 64'(1));
    chk("rst_acks",    64'({m0ack_o, m1ack_o}), 64'(0));
    chk("rst_errs",    64'({m0err_o, m1err_o}), 64'(0));
    chk("rst_scyc_sstb", 64'({scyc_o, sstb_o}), 64'(0));
    chk("rst_sadr",    sadr_o, 64'(0));
    chk("rst_sdat_swe_ssel", 64'({sdat_o, swe_o, ssel_o}), 64'(0));
    #10 reset_ni = 1'b1;

    // ---------------- tie from IDLE, twice ----------------
    $display("txn tie #1");
    m0cyc_i = 1; m1cyc_i = 1;
    #1; chk("tie_idle_m1stall", 64'(m1stall_o), 64'(1));
    tick();
    #1;
    chk("tie1_m0stall", 64'(m0stall_o), RR ? 64'(0) : 64'(1));
    chk("tie1_m1stall", 64'(m1stall_o), RR ? 64'(1) : 64'(0));
    chk("tie1_scyc", 64'(scyc_o), 64'(1));
    m0cyc_i = 0; m1cyc_i = 0;
    tick();
    $display("txn tie #2");
    m0cyc_i = 1; m1cyc_i = 1;
    tick();
    #1;
    chk("tie2_m0stall", 64'(m0stall_o), 64'(1));
    chk("tie2_m1stall", 64'(m1stall_o), 64'(0));
    m0cyc_i = 0; m1cyc_i = 0;
    tick();

    // ---------------- single master read ----------------
    $display("txn m0 read adr=0x1000");
    m0cyc_i = 1; m0stb_i = 1; m0adr_i = 64'h1000; m0sel_i = 2'b11;
    #1;
    chk("s1_idle_scyc", 64'(scyc_o), 64'(0));
    chk("s1_idle_m0stall", 64'(m0stall_o), 64'(1));
    tick();
    #1;
    chk("s1_sadr", sadr_o, 64'h1000);
    chk("s1_sstb", 64'(sstb_o), 64'(1));
    chk("s1_ssel", 64'(ssel_o), 64'(3));
    chk("s1_m0stall", 64'(m0stall_o), 64'(0));
    chk("s1_m1stall_g", 64'(m1stall_o), 64'(1));
    tick();
    m0stb_i = 0; sack_i = 1; sdat_i = 16'hBEEF;
    #1;
    chk("s1_m0ack", 64'(m0ack_o), 64'(1));
    chk("s1_m1ack", 64'(m1ack_o), 64'(0));
    chk("s1_m0dat", 64'(m0dat_o), 64'hBEEF);
    chk("s1_m1dat", 64'(m1dat_o), 64'hBEEF);
    chk("s1_m1stall_a", 64'(m1stall_o), 64'(1));
    tick();
    sack_i = 0; m0cyc_i = 0;
    #1; chk("s1_m0ack_end", 64'(m0ack_o), 64'(0));
    tick();
    #1;
    chk("s1_idle_sadr", sadr_o, 64'(0));
    chk("s1_idle_stall", 64'(m0stall_o), 64'(1));

    // ---------------- 4-beat read with hand-off ----------------
    $display("txn m0 4-beat read adr=0x2000, m1 waits");
    m0cyc_i = 1; m0stb_i = 1; m0adr_i = 64'h2000;
    tick();
    m1cyc_i = 1; m1stb_i = 1; m1we_i = 1; m1adr_i = 64'h3000;
    m1dat_i = 16'h5A5A; m1sel_i = 2'b10;
    #1;
    chk("ho_sadr_m0", sadr_o, 64'h2000);
    chk("ho_m1stall", 64'(m1stall_o), 64'(1));
    tick();
    sack_i = 1;
    #1;
    chk("ho_m0ack_b1", 64'(m0ack_o), 64'(1));
    chk("ho_m1ack", 64'(m1ack_o), 64'(0));
    tick();
    tick();
    m0stb_i = 0;
    tick();
    #1;
    chk("ho_m0ack_b4", 64'(m0ack_o), 64'(1));
    chk("ho_m1stall_b4", 64'(m1stall_o), 64'(1));
    m0stb_i = 0; sack_i = 0;
    tick();
    m0cyc_i = 0;
    #1;
    chk("ho_scyc_drop", 64'(scyc_o), 64'(0));
    chk("ho_m1stall_drop", 64'(m1stall_o), 64'(1));
    tick();
    $display("txn m1 write adr=0x3000 (hand-off)");
    #1;
    chk("ho_g1_scyc", 64'(scyc_o), 64'(1));
    chk("ho_g1_sadr", sadr_o, 64'h3000);
    chk("ho_g1_swe_ssel", 64'({swe_o, ssel_o}), 64'(3'b110));
    chk("ho_g1_sdat", 64'(sdat_o), 64'h5A5A);
    chk("ho_g1_m1stall", 64'(m1stall_o), 64'(0));
    chk("ho_g1_m0stall", 64'(m0stall_o), 64'(1));
    sstall_i = 1;
    #1; chk("ho_g1_stall_pass", 64'(m1stall_o), 64'(1));
    sstall_i = 0;
    tick();
    m1stb_i = 0; sack_i = 1;
    #1;
    chk("ho_g1_m1ack", 64'(m1ack_o), 64'(1));
    chk("ho_g1_m0ack", 64'(m0ack_o), 64'(0));
    tick();
    m1cyc_i = 0; sack_i = 0; m1we_i = 0;
    tick();
    #1; chk("ho_idle_m1stall", 64'(m1stall_o), 64'(1));

    // ---------------- watchdog timeout ----------------
    // Last clear is the accepted strobe in the first granted cycle (count is
    // 0 after edge E1). Counts 1..14 follow at E2..E15; the cycle after E15
    // would land on 15, so the error is registered at E16.
    $display("txn m0 read adr=0x4000, slave never acks");
    m0cyc_i = 1; m0stb_i = 1; m0adr_i = 64'h4000;
    tick();                       // E0: granted
    tick();                       // E1: strobe accepted, count cleared
    m0stb_i = 0;
    for (int i = 2; i <= 15; i++) begin
      tick();
      #1; chk($sformatf("to_noerr_e%0d", i), 64'(m0err_o), 64'(0));
    end
    tick();                       // E16
    #1;
    chk("to_m0err", 64'(m0err_o), 64'(1));
    chk("to_m1err", 64'(m1err_o), 64'(0));
    chk("to_scyc", 64'(scyc_o), 64'(0));
    chk("to_m0stall", 64'(m0stall_o), 64'(1));
    tick();                       // E17: pulse over, draining
    sack_i = 1;
    #1;
    chk("to_err_pulse_end", 64'(m0err_o), 64'(0));
    chk("to_late_ack", 64'(m0ack_o), 64'(0));
    chk("to_drain_scyc", 64'(scyc_o), 64'(0));
    tick();
    sack_i = 0;
    #1; chk("to_drain_held", 64'(m0stall_o), 64'(1));
    m0cyc_i = 0;
    tick();

    // ---------------- ack exactly at the limit ----------------
    $display("txn m0 read adr=0x5000, ack at watchdog limit");
    m0cyc_i = 1; m0stb_i = 1; m0adr_i = 64'h5000;
    tick();                       // E0: granted (also proves drain was left)
    #1; chk("al_granted", 64'(m0stall_o), 64'(0));
    tick();                       // E1
    m0stb_i = 0;
    repeat (14) tick();           // E15
    sack_i = 1;
    #1; chk("al_m0ack", 64'(m0ack_o), 64'(1));
    tick();                       // E16
    sack_i = 0;
    #1;
    chk("al_no_err", 64'(m0err_o), 64'(0));
    chk("al_scyc", 64'(scyc_o), 64'(1));
    chk("al_still_g0", 64'(m0stall_o), 64'(0));
    tick();
    #1; chk("al_no_err_late", 64'(m0err_o), 64'(0));
    m0cyc_i = 0;
    tick();

    // ---------------- asynchronous reset mid-transfer ----------------
    $display("txn m1 read adr=0x6000, async reset");
    m1cyc_i = 1; m1stb_i = 1; m1adr_i = 64'h6000;
    tick();
    #1; chk("ar_pre_scyc", 64'(scyc_o), 64'(1));
    reset_ni = 0;
    sack_i = 1;
    #1;
    chk("ar_scyc_sstb", 64'({scyc_o, sstb_o}), 64'(0));
    chk("ar_sadr", sadr_o, 64'(0));
    chk("ar_stalls", 64'({m0stall_o, m1stall_o}), 64'(3));
    chk("ar_m1ack", 64'(m1ack_o), 64'(0));
    #2 reset_ni = 1;
    sack_i = 0;
    #1; chk("ar_post_idle", 64'(m1stall_o), 64'(1));
    tick();
    #1;
    chk("ar_regrant_scyc", 64'(scyc_o), 64'(1));
    chk("ar_regrant_m1stall", 64'(m1stall_o), 64'(0));
    chk("ar_regrant_sadr", sadr_o, 64'h6000);
    m1cyc_i = 0; m1stb_i = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
